// File: rtl/tcdm_l2_bank_responder_if.sv
// XBAR_TCDM_BUS request/grant/response bundle.
// Request side : req_i, add_i (byte address), wen_i (1 = read), wdata_i, be_i
// Response side: gnt_o (combinational), r_valid_o, r_rdata_o, r_opc_o (registered)
// The _i/_o suffixes are seen from the bank (slave) side.
interface tcdm_l2_bank_responder_if;
    logic        req_i;
    logic [31:0] add_i;
    logic        wen_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;
    logic        r_opc_o;

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i,
        output gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );
endinterface

// File: rtl/tcdm_l2_bank_responder.sv
// Single-port L2 bank responder for the XBAR_TCDM_BUS protocol.
// Word-organised SRAM with byte-enabled writes, optional grant wait states and an
// out-of-range error flag returned on r_opc_o.
// Ports:
//   clk_i : clock
//   rst_i : synchronous reset, active-high (SRAM contents are not reset)
//   bus   : slave side of the request/grant/response bundle
module tcdm_l2_bank_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1C000000,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ERR_RDATA   = 32'hBADACCE5
) (
    input logic                       clk_i,
    input logic                       rst_i,
    tcdm_l2_bank_responder_if.slave   bus
);

    localparam int unsigned IdxW     = $clog2(MEM_WORDS);
    localparam logic [32:0] MemBytes = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       gnt;

    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] idx;

    logic [31:0] mem [MEM_WORDS];

    logic        r_valid_q;
    logic [31:0] r_rdata_q;
    logic        r_opc_q;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
    assign offset   = bus.add_i - BASE_ADDR;
    assign in_range = {1'b0, offset} < MemBytes;
    assign idx      = offset[IdxW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        if (!rst_i) begin
            if (state_q == StIdle) begin
                if (WAIT_CYCLES == 0) begin
                    gnt = bus.req_i;
                end else if (bus.req_i) begin
                    cnt_d   = WaitInit;
                    state_d = StWait;
                end
            end else begin
                if (!bus.req_i) begin
                    // Master withdrew the request: drop the pending wait silently.
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    gnt     = 1'b1;
                    state_d = StIdle;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // gnt is forced low during reset, so no write can slip through then.
    always_ff @(posedge clk_i) begin
        if (gnt && !bus.wen_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be_i[k]) begin
                    mem[idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_rdata_q <= 32'd0;
            r_opc_q   <= 1'b0;
        end else if (gnt) begin
            r_valid_q <= 1'b1;
            r_opc_q   <= !in_range;
            if (bus.wen_i) begin
                r_rdata_q <= in_range ? mem[idx] : ERR_RDATA;
            end else begin
                r_rdata_q <= 32'd0;
            end
        end else begin
            r_valid_q <= 1'b0;
        end
    end

    assign bus.gnt_o     = gnt;
    assign bus.r_valid_o = r_valid_q;
    assign bus.r_rdata_o = r_rdata_q;
    assign bus.r_opc_o   = r_opc_q;

endmodule

// File: tb/tb_tcdm_l2_bank_responder.sv
// Self-checking bench: two banks (0 and 3 wait states), a transaction-level model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_tcdm_l2_bank_responder;

    localparam logic [31:0] Base  = 32'h1C000000;
    localparam int          Words = 16;
    localparam logic [31:0] Err   = 32'hBADACCE5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;

    tcdm_l2_bank_responder_if b0 ();
    tcdm_l2_bank_responder_if b1 ();

    tcdm_l2_bank_responder #(
        .BASE_ADDR(Base), .MEM_WORDS(Words), .WAIT_CYCLES(0), .ERR_RDATA(Err)
    ) dut0 (
        .clk_i(clk), .rst_i(rst0), .bus(b0)
    );

    tcdm_l2_bank_responder #(
        .BASE_ADDR(Base), .MEM_WORDS(Words), .WAIT_CYCLES(3), .ERR_RDATA(Err)
    ) dut1 (
        .clk_i(clk), .rst_i(rst1), .bus(b1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (one slot per bank) ----------------
    logic [31:0] mmem   [2][Words];
    logic [3:0]  mknown [2][Words];
    int          waited [2];
    logic        exp_rv [2];
    logic [31:0] exp_rd [2];
    logic        exp_rd_ok [2];
    logic        exp_opc [2];
    bit          primed [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            primed[i] = 0;
            waited[i] = 0;
            for (int w = 0; w < Words; w++) mknown[i][w] = 4'h0;
        end
    end

    // A request is granted once it has been held for WAIT_CYCLES cycles without a grant.
    task automatic model_cycle(input int i, input int nwait, input logic rst,
                               input logic req, input logic [31:0] add, input logic wen,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic gnt, input logic rv, input logic [31:0] rd,
                               input logic opc);
        logic        exp_g;
        logic [31:0] off;
        bit          inr;
        int          idx;
        exp_g = !rst && req && (waited[i] == nwait);
        if (primed[i]) begin
            chk($sformatf("b%0d_gnt", i), {31'd0, gnt}, {31'd0, exp_g});
            chk($sformatf("b%0d_rvalid", i), {31'd0, rv}, {31'd0, exp_rv[i]});
            if (exp_rd_ok[i]) chk($sformatf("b%0d_rdata", i), rd, exp_rd[i]);
            chk($sformatf("b%0d_ropc", i), {31'd0, opc}, {31'd0, exp_opc[i]});
        end
        if (rst) begin
            primed[i]    = 1;
            exp_rv[i]    = 1'b0;
            exp_rd[i]    = 32'd0;
            exp_rd_ok[i] = 1'b1;
            exp_opc[i]   = 1'b0;
            waited[i]    = 0;
        end else if (exp_g) begin
            off = add - Base;
            inr = off < 32'(Words * 4);
            idx = int'(off / 4);
            exp_rv[i]  = 1'b1;
            exp_opc[i] = !inr;
            if (wen) begin
                if (inr) begin
                    exp_rd[i]    = mmem[i][idx];
                    exp_rd_ok[i] = (mknown[i][idx] == 4'hF);
                end else begin
                    exp_rd[i]    = Err;
                    exp_rd_ok[i] = 1'b1;
                end
            end else begin
                exp_rd[i]    = 32'd0;
                exp_rd_ok[i] = 1'b1;
                if (inr) begin
                    for (int k = 0; k < 4; k++)
                        if (be[k]) mmem[i][idx][8*k +: 8] = wdata[8*k +: 8];
                    mknown[i][idx] = mknown[i][idx] | be;
                end
            end
            waited[i] = 0;
        end else begin
            exp_rv[i] = 1'b0;
            waited[i] = req ? waited[i] + 1 : 0;
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0, 0, rst0, b0.req_i, b0.add_i, b0.wen_i, b0.wdata_i, b0.be_i,
                    b0.gnt_o, b0.r_valid_o, b0.r_rdata_o, b0.r_opc_o);
        model_cycle(1, 3, rst1, b1.req_i, b1.add_i, b1.wen_i, b1.wdata_i, b1.be_i,
                    b1.gnt_o, b1.r_valid_o, b1.r_rdata_o, b1.r_opc_o);
    end

    // ---------------- stimulus helpers: drive after posedge, return at negedge ----------------
    task automatic d0(input logic rst, input logic req, input logic wen,
                      input logic [31:0] add, input logic [31:0] wdata, input logic [3:0] be);
        @(posedge clk);
        #1;
        rst0 = rst; b0.req_i = req; b0.wen_i = wen; b0.add_i = add;
        b0.wdata_i = wdata; b0.be_i = be;
        @(negedge clk);
    endtask

    task automatic d1(input logic rst, input logic req, input logic wen,
                      input logic [31:0] add, input logic [31:0] wdata, input logic [3:0] be);
        @(posedge clk);
        #1;
        rst1 = rst; b1.req_i = req; b1.wen_i = wen; b1.add_i = add;
        b1.wdata_i = wdata; b1.be_i = be;
        @(negedge clk);
    endtask

    // Hold a request on bank 1 until granted, with a bounded wait.
    task automatic xact1(input logic wen, input logic [31:0] add, input logic [31:0] wdata,
                         input logic [3:0] be);
        d1(1'b0, 1'b1, wen, add, wdata, be);
        for (int n = 0; n < 20 && b1.gnt_o !== 1'b1; n++) d1(1'b0, 1'b1, wen, add, wdata, be);
        if (b1.gnt_o !== 1'b1) chk("b1_grant_timeout", {31'd0, b1.gnt_o}, 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r < 16) return Base + 32'(4 * r) + 32'($urandom_range(0, 3));
        else if (r < 18) return Base + 32'(Words * 4) + 32'(4 * (r - 16));
        else if (r == 18) return Base - 32'd4;
        else return $urandom;
    endfunction

    task automatic run0();
        int g;
        int v;
        d0(1, 0, 1, 0, 0, 0);
        d0(1, 0, 1, 0, 0, 0);
        for (int w = 0; w < Words; w++)
            d0(0, 1, 0, Base + 32'(4 * w), 32'hC0DE0000 | 32'(w), 4'hF);
        d0(0, 0, 1, 0, 0, 0);

        // Write then read back-to-back.
        d0(0, 1, 0, Base, 32'h12345678, 4'hF);
        chk("t1_wr_gnt", {31'd0, b0.gnt_o}, 32'd1);
        d0(0, 1, 1, Base, 0, 0);
        chk("t1_rd_gnt", {31'd0, b0.gnt_o}, 32'd1);
        chk("t1_wr_rvalid", {31'd0, b0.r_valid_o}, 32'd1);
        chk("t1_wr_rdata", b0.r_rdata_o, 32'd0);
        d0(0, 0, 1, 0, 0, 0);
        chk("t1_rd_rvalid", {31'd0, b0.r_valid_o}, 32'd1);
        chk("t1_rd_rdata", b0.r_rdata_o, 32'h12345678);
        chk("t1_rd_opc", {31'd0, b0.r_opc_o}, 32'd0);

        // Byte enables.
        d0(0, 1, 0, Base + 4, 32'hFFFFFFFF, 4'hF);
        d0(0, 1, 0, Base + 4, 32'hAABBCCDD, 4'b0101);
        d0(0, 1, 1, Base + 4, 0, 0);
        d0(0, 0, 1, 0, 0, 0);
        chk("be_rdata", b0.r_rdata_o, 32'hFFBBFFDD);

        // Out-of-range read just past the end.
        d0(0, 1, 1, Base + 32'(Words * 4), 0, 0);
        chk("oor_rd_gnt", {31'd0, b0.gnt_o}, 32'd1);
        d0(0, 0, 1, 0, 0, 0);
        chk("oor_rd_rvalid", {31'd0, b0.r_valid_o}, 32'd1);
        chk("oor_rd_opc", {31'd0, b0.r_opc_o}, 32'd1);
        chk("oor_rd_rdata", b0.r_rdata_o, 32'hBADACCE5);

        // Out-of-range write below base, then last word.
        d0(0, 1, 0, Base - 4, 32'hDEAD0000, 4'hF);
        d0(0, 1, 1, Base + 32'(Words * 4 - 4), 0, 0);
        chk("oor_wr_opc", {31'd0, b0.r_opc_o}, 32'd1);
        chk("oor_wr_rdata", b0.r_rdata_o, 32'd0);
        d0(0, 0, 1, 0, 0, 0);
        chk("last_word", b0.r_rdata_o, 32'hC0DE000F);
        chk("last_word_opc", {31'd0, b0.r_opc_o}, 32'd0);

        // Pipelined alternating stream; words 4..13 only.
        g = 0;
        v = 0;
        for (int k = 0; k < 16; k++) begin
            d0(0, 1, (k % 2) == 1, Base + 32'(4 * $urandom_range(4, 13)), $urandom,
               4'($urandom_range(0, 15)));
            if (b0.gnt_o === 1'b1) g++;
            if (k > 0 && b0.r_valid_o === 1'b1) v++;
        end
        d0(0, 0, 1, 0, 0, 0);
        if (b0.r_valid_o === 1'b1) v++;
        chk("stream_grants", 32'(g), 32'd16);
        chk("stream_valids", 32'(v), 32'd16);

        // Reset in the cycle a write would be granted.
        d0(1, 1, 0, Base + 8, 32'h55555555, 4'hF);
        chk("rst_gnt", {31'd0, b0.gnt_o}, 32'd0);
        d0(0, 0, 1, 0, 0, 0);
        chk("rst_rvalid", {31'd0, b0.r_valid_o}, 32'd0);
        d0(0, 1, 1, Base + 8, 0, 0);
        d0(0, 0, 1, 0, 0, 0);
        chk("rst_word_kept", b0.r_rdata_o, 32'hC0DE0002);

        repeat (400) begin
            d0($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
               rand_addr(), $urandom, 4'($urandom_range(0, 15)));
        end
        d0(0, 0, 1, 0, 0, 0);
        d0(0, 0, 1, 0, 0, 0);
    endtask

    task automatic run1();
        d1(1, 0, 1, 0, 0, 0);
        d1(1, 0, 1, 0, 0, 0);
        for (int w = 0; w < Words; w++)
            xact1(0, Base + 32'(4 * w), 32'hC0DE1000 | 32'(w), 4'hF);
        d1(0, 0, 1, 0, 0, 0);

        // Held read: three non-granting cycles, grant on the fourth.
        for (int k = 0; k < 4; k++) begin
            d1(0, 1, 1, Base + 12, 0, 0);
            chk($sformatf("w3_gnt_c%0d", k), {31'd0, b1.gnt_o}, (k == 3) ? 32'd1 : 32'd0);
        end
        d1(0, 0, 1, 0, 0, 0);
        chk("w3_rvalid", {31'd0, b1.r_valid_o}, 32'd1);
        chk("w3_rdata", b1.r_rdata_o, 32'hC0DE1003);

        // Abort after one wait cycle.
        d1(0, 1, 1, Base + 16, 0, 0);
        chk("abort_gnt0", {31'd0, b1.gnt_o}, 32'd0);
        d1(0, 0, 1, 0, 0, 0);
        chk("abort_gnt1", {31'd0, b1.gnt_o}, 32'd0);
        chk("abort_rvalid1", {31'd0, b1.r_valid_o}, 32'd0);
        d1(0, 0, 1, 0, 0, 0);
        chk("abort_rvalid2", {31'd0, b1.r_valid_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            d1(0, 1, 1, Base + 16, 0, 0);
            chk($sformatf("reissue_gnt_c%0d", k), {31'd0, b1.gnt_o},
                (k == 3) ? 32'd1 : 32'd0);
        end
        d1(0, 0, 1, 0, 0, 0);
        chk("reissue_rdata", b1.r_rdata_o, 32'hC0DE1004);

        repeat (400) begin
            d1($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, 1'($urandom),
               rand_addr(), $urandom, 4'($urandom_range(0, 15)));
        end
        d1(0, 0, 1, 0, 0, 0);
        d1(0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        b0.req_i = 1'b0; b0.wen_i = 1'b1; b0.add_i = '0; b0.wdata_i = '0; b0.be_i = '0;
        b1.req_i = 1'b0; b1.wen_i = 1'b1; b1.add_i = '0; b1.wdata_i = '0; b1.be_i = '0;
        fork
            run0();
            run1();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
